// File: rtl/grant_burst_mux.sv
// grant_burst_mux: locks onto the requester named by a one-hot arbiter grant,
// moves exactly BurstLen beats from it to one shared valid/ready output port,
// then pulses that requester's done strobe before accepting a new grant.
module grant_burst_mux #(
    parameter int NumReq   = 3,
    parameter int DataW    = 8,
    parameter int BurstLen = 4
) (
    input  logic                                        clk,
    input  logic                                        rstN,
    input  logic [NumReq-1:0]                           grant_in,
    input  logic [NumReq*DataW-1:0]                     req_data,
    input  logic [NumReq-1:0]                           req_valid,
    output logic [NumReq-1:0]                           req_ready,
    output logic [DataW-1:0]                            out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] out_src,
    output logic                                        out_last,
    output logic [NumReq-1:0]                           done_out,
    output logic                                        busy,
    output logic                                        grant_err
);

    localparam int SrcW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = $clog2(BurstLen + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BurstLen);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [SrcW-1:0]     src_q, src_d;
    logic [DataW-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic [NumReq-1:0]   done_q, done_d;
    logic                gerr_q, gerr_d;

    logic [SrcW-1:0]     grant_idx;
    logic                grant_one;
    logic                grant_multi;
    logic [DataW-1:0]    own_data;
    logic                own_valid;
    logic                own_ready;
    logic [NumReq-1:0]   own_onehot;
    logic [CntW-1:0]     cnt_inc;
    logic                accept;

    // Decode the arbiter grant: owner index, and whether it is one-hot or multi-hot.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_in[i]) grant_idx = SrcW'(i);
        end
        grant_one   = $onehot(grant_in);
        grant_multi = (grant_in != '0) && !grant_one;
    end

    // Select the locked owner's payload/valid and drive its ready; other readies stay low.
    always_comb begin
        own_data   = '0;
        own_valid  = 1'b0;
        own_onehot = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (src_q == SrcW'(i)) begin
                own_data      = req_data[i*DataW +: DataW];
                own_valid     = req_valid[i];
                own_onehot[i] = 1'b1;
            end
        end
        own_ready = (state_q == XFER) && (!valid_q || out_ready) && (cnt_q < LastCnt);
        req_ready = own_ready ? own_onehot : '0;
        accept    = own_valid && own_ready;
        cnt_inc   = cnt_q + CntW'(1);
    end

    // Burst sequencing: next state, output register and completion strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = '0;
        gerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_one) begin
                    src_d   = grant_idx;
                    busy_d  = 1'b1;
                    state_d = XFER;
                end else if (grant_multi) begin
                    gerr_d = 1'b1;
                end
            end
            XFER: begin
                if (accept) begin
                    // A new beat overwrites the register even if the old one is leaving now.
                    data_d  = own_data;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                    last_d  = (cnt_inc == LastCnt);
                    if (cnt_inc == LastCnt) state_d = DRAIN;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                        done_d  = own_onehot;
                    end
                end
            end
            DONE: begin
                // Grant deliberately not sampled here so the arbiter sees done first.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            gerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gerr_q  <= gerr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_src   = src_q;
    assign done_out  = done_q;
    assign busy      = busy_q;
    assign grant_err = gerr_q;

endmodule

// File: doc/grant_burst_mux.md
Name: grant_burst_mux

Overview:
- Downstream consumer of the cyclic-lottery arbiter's one-hot grant vector.
- Locks onto the granted requester and moves exactly BurstLen data beats from that requester to a single shared output port, using valid/ready handshakes on both sides.
- Pulses a per-requester done strobe when the burst completes, so the requester can drop or renew its request to the arbiter.
- Ignores grant changes while a burst is in flight.

Parameters:
- NumReq, 3, number of requesters; matches the arbiter's request/grant vector width.
- DataW, 8, payload width per beat.
- BurstLen, 4, beats per granted transaction; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- grant_in  in  NumReq  one-hot grant from the arbiter; bit i grants requester i.
- req_data  in  NumReq*DataW  packed payloads; requester i occupies bits [i*DataW +: DataW].
- req_valid  in  NumReq  per-requester beat valid.
- req_ready  out  NumReq  per-requester beat ready.
- out_data  out  DataW  registered output payload.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_src  out  max(1,$clog2(NumReq))  index of the requester owning the current burst.
- out_last  out  1  high on the final beat of a burst.
- done_out  out  NumReq  one-cycle completion pulse to the owning requester.
- busy  out  1  high from burst lock until DONE exit.
- grant_err  out  1  one-cycle pulse when grant_in is multi-hot in IDLE.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, out_src=0, done_out=0, busy=0, grant_err=0, req_ready=0, state=IDLE, beat count=0.
- Reset asserted mid-burst abandons the burst: no done pulse, and the partial beat in the output register is dropped.
- States are IDLE, XFER, DRAIN, DONE.
- IDLE:
  - grant_in==0: stay in IDLE.
  - grant_in exactly one-hot: latch owner index into out_src, clear count, busy=1, go to XFER next edge.
  - grant_in multi-hot: pulse grant_err for 1 cycle, stay in IDLE, latch nothing.
- XFER:
  - req_ready[owner] = (!out_valid || out_ready) && count<BurstLen. All other req_ready bits are 0.
  - Accept when req_valid[owner] && req_ready[owner]:
    - load out_data = owner slice, out_valid=1, count+=1;
    - out_last=1 iff the new count==BurstLen.
  - An output handshake (out_valid && out_ready) with no new accept clears out_valid and out_last.
  - After the beat with count==BurstLen is accepted, go to DRAIN.
- DRAIN: req_ready=0. Go to DONE on the last beat's output handshake (out_valid && out_ready && out_last). out_valid/out_last clear on that edge.
- DONE (1 cycle): done_out[owner]=1. On the next edge: busy=0, done_out=0, go to IDLE.
- A grant is never sampled in DONE. The arbiter gets a full cycle to react before re-grant, so a held grant restarts a burst from IDLE.
- Latency:
  - Grant sampled at edge k → req_ready may assert in cycle k+1 → first out_valid earliest at edge k+2.
  - Full-throughput burst: last out_valid cycle k+1+BurstLen; done_out in cycle k+2+BurstLen.
- Throughput is 1 beat/cycle when out_ready and req_valid are held high. Backpressure stalls with no data loss.
- out_data/out_last are stable while out_valid && !out_ready.
- grant_in changes in XFER, DRAIN or DONE are ignored; owner stays locked. Non-owner req_valid is ignored.
- Count width is $clog2(BurstLen+1). No wrap-around; the count saturates at BurstLen and clears in IDLE.
- BurstLen=1: the single accepted beat carries out_last.

Test Plan:
- Reset, grant_in=3'b000 for 10 cycles → busy=0, out_valid=0, all req_ready=0, done_out=0.
- grant_in=3'b100, req_valid=3'b100, req_data[23:16]=8'hA0..A3 successively, out_ready=1 → out_src=2; out_data A0,A1,A2,A3 on consecutive cycles; out_last only with A3; done_out=3'b100 for exactly 1 cycle; busy falls the following cycle.
- Same burst with out_ready toggling 1,0,0,1,… → out_data held constant while stalled; all 4 beats delivered in order, none duplicated; req_ready[2] low during stalls once the register is full.
- grant_in switches 3'b001→3'b010 mid-burst of requester 0 → beats come only from requester 0; done_out=3'b001; the requester-1 burst starts only after the DONE cycle.
- grant_in=3'b111 in IDLE → grant_err pulses 1 cycle; no state change; busy stays 0.
- rstN pulled low after 2 beats of a burst → all outputs return to reset values immediately; no done_out; after rstN=1 with grant 3'b010, a fresh 4-beat burst completes.
